// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Program-counter and instruction-fetch controller for the IF stage.
// It owns the fetch PC and a small three-state FSM (BOOT, RUN, FAULT).
// On every cycle it decides what the IF/ID register captures:
//   - the fetched instruction,
//   - a NOP bubble (redirect, fetch fault, boot), or
//   - nothing (hazard stall).
// A fetch from an invalid address parks the stage in FAULT, emitting bubbles.
// It leaves FAULT when either an older branch squashes it or the trap handler
// acknowledges it.
//
// Parameters
//   RESET_VEC     PC loaded by reset
//   TRAP_VEC      PC loaded when a pending fault is acknowledged
//   NOP_INSTR     bubble instruction (addi x0,x0,0)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   pc_write      hazard-unit enable, 0 stalls fetch
//   branch_taken  redirect request from execute
//   branch_target redirect address
//   inv_addr      fetch memory flags the current pc as invalid
//   instr_in      instruction fetched at the current pc
//   trap_ack      trap handler accepts the pending fetch fault
//   pc            registered fetch address
//   instr_out     instruction presented to IF/ID (combinational)
//   if_id_write   IF/ID write enable (combinational)
//   if_flush      high while a redirect bubble is inserted (combinational)
//   fetch_fault   registered, high while in FAULT
//   fault_pc      registered address of the most recent faulting fetch
//   fetch_cnt     (PC_FETCH_PERF_CNT_EN only) count of normal sequential fetches
//   flush_cnt     (PC_FETCH_PERF_CNT_EN only) count of cycles with if_flush=1
//
// Optional feature
//   Define PC_FETCH_PERF_CNT_EN to add the fetch_cnt/flush_cnt counters and ports.
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [63:0] RESET_VEC = 64'h0,
    parameter logic [63:0] TRAP_VEC  = 64'h100,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        inv_addr,
    input  logic [31:0] instr_in,
    input  logic        trap_ack,
    output logic [63:0] pc,
`ifdef PC_FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic [31:0] instr_out,
    output logic        if_id_write,
    output logic        if_flush,
    output logic        fetch_fault,
    output logic [63:0] fault_pc
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [63:0] pc_reg;
    logic [63:0] pc_next;
    logic        fault_reg;
    logic        fault_next;
    logic [63:0] fault_pc_reg;
    logic [63:0] fault_pc_next;
    logic        normal_fetch;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_VEC;
            fault_reg    <= 1'b0;
            fault_pc_reg <= 64'h0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            fault_reg    <= fault_next;
            fault_pc_reg <= fault_pc_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        fault_next    = fault_reg;
        fault_pc_next = fault_pc_reg;
        instr_out     = NOP_INSTR;
        if_id_write   = 1'b0;
        if_flush      = 1'b0;
        normal_fetch  = 1'b0;

        case (state_reg)
            ST_BOOT: begin
                // One settling cycle: nothing is written to IF/ID, pc is kept.
                state_next = ST_RUN;
            end

            ST_RUN: begin
                if (branch_taken) begin
                    // Redirect overrides a stall: the wrong-path fetch becomes a bubble.
                    pc_next     = branch_target;
                    if_flush    = 1'b1;
                    if_id_write = 1'b1;
                end else if (inv_addr) begin
                    // Park on the faulting address; IF/ID gets a bubble.
                    state_next    = ST_FAULT;
                    fault_next    = 1'b1;
                    fault_pc_next = pc_reg;
                    if_id_write   = 1'b1;
                end else if (!pc_write) begin
                    instr_out = instr_in;
                end else begin
                    pc_next      = pc_reg + 64'd4;
                    instr_out    = instr_in;
                    if_id_write  = 1'b1;
                    normal_fetch = 1'b1;
                end
            end

            ST_FAULT: begin
                // Bubbles every cycle; a branch from an older instruction
                // squashes the speculative fault and beats trap_ack.
                if_id_write = 1'b1;
                if (branch_taken) begin
                    pc_next    = branch_target;
                    fault_next = 1'b0;
                    state_next = ST_RUN;
                    if_flush   = 1'b1;
                end else if (trap_ack) begin
                    pc_next    = TRAP_VEC;
                    fault_next = 1'b0;
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    assign pc          = pc_reg;
    assign fetch_fault = fault_reg;
    assign fault_pc    = fault_pc_reg;

`ifdef PC_FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg;
    logic [15:0] flush_cnt_reg;

    // Free-running event counters; they wrap naturally on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_reg <= 32'h0;
            flush_cnt_reg <= 16'h0;
        end else begin
            if (normal_fetch) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (if_flush) begin
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    // Only the counters consume this strobe.
    logic unused_normal_fetch;
    assign unused_normal_fetch = normal_fetch;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Directed testbench for pc_fetch_ctrl with hand-computed expectations.
//
// Timing scheme:
//   - Inputs change 1 time unit after a rising edge.
//   - Combinational outputs are checked 1 time unit after the inputs settle.
//   - Registered outputs are checked 1 time unit after the next rising edge.
//
// Counter checks are compiled in only when PC_FETCH_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] INS = 32'hDEADBEEF;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        inv_addr;
    logic [31:0] instr_in;
    logic        trap_ack;
    logic [63:0] pc;
    logic [31:0] instr_out;
    logic        if_id_write;
    logic        if_flush;
    logic        fetch_fault;
    logic [63:0] fault_pc;
`ifdef PC_FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    pc_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .inv_addr      (inv_addr),
        .instr_in      (instr_in),
        .trap_ack      (trap_ack),
        .pc            (pc),
`ifdef PC_FETCH_PERF_CNT_EN
        .fetch_cnt     (fetch_cnt),
        .flush_cnt     (flush_cnt),
`endif
        .instr_out     (instr_out),
        .if_id_write   (if_id_write),
        .if_flush      (if_flush),
        .fetch_fault   (fetch_fault),
        .fault_pc      (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_cnt++;
        if (observed === expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a new input vector and let combinational outputs settle.
    task automatic drive(input logic pw, input logic bt, input logic [63:0] tgt,
                         input logic ia, input logic ta);
        pc_write      = pw;
        branch_taken  = bt;
        branch_target = tgt;
        inv_addr      = ia;
        trap_ack      = ta;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        instr_in = INS;
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state
        check("rst_pc", pc, 64'h0);
        check("rst_fault", {63'h0, fetch_fault}, 64'h0);
        check("rst_fault_pc", fault_pc, 64'h0);

        // Boot cycle: no IF/ID write, bubble presented
        rst_n = 1'b1;
        #1;
        check("boot_ifid", {63'h0, if_id_write}, 64'h0);
        check("boot_instr", {32'h0, instr_out}, {32'h0, NOP});
        check("boot_flush", {63'h0, if_flush}, 64'h0);
        check("boot_pc", pc, 64'h0);

        // Sequential fetch: 0,4,8,C
        tick();
        check("run_pc0", pc, 64'h0);
        check("run_ifid", {63'h0, if_id_write}, 64'h1);
        check("run_instr", {32'h0, instr_out}, {32'h0, INS});
        tick();
        check("run_pc4", pc, 64'h4);
        tick();
        check("run_pc8", pc, 64'h8);
        tick();
        check("run_pcc", pc, 64'hC);
        tick();
        check("run_pc10", pc, 64'h10);

        // Stall for two cycles at 0x10
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        check("stall_ifid", {63'h0, if_id_write}, 64'h0);
        check("stall_instr", {32'h0, instr_out}, {32'h0, INS});
        tick();
        check("stall_pc1", pc, 64'h10);
        tick();
        check("stall_pc2", pc, 64'h10);
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        tick();
        check("unstall_pc", pc, 64'h14);

        // Branch to 0x20, then branch to 0x80 while stalled
        drive(1'b1, 1'b1, 64'h20, 1'b0, 1'b0);
        tick();
        check("br_pc20", pc, 64'h20);
        drive(1'b0, 1'b1, 64'h80, 1'b0, 1'b0);
        check("br_flush", {63'h0, if_flush}, 64'h1);
        check("br_instr", {32'h0, instr_out}, {32'h0, NOP});
        check("br_ifid", {63'h0, if_id_write}, 64'h1);
        tick();
        check("br_pc80", pc, 64'h80);

        // trap_ack outside FAULT does nothing
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        check("tack_run_flush", {63'h0, if_flush}, 64'h0);
        tick();
        check("tack_run_pc", pc, 64'h84);
        check("tack_run_fault", {63'h0, fetch_fault}, 64'h0);

        // Fault at 0x1002, then trap acknowledge
        drive(1'b1, 1'b1, 64'h1002, 1'b0, 1'b0);
        tick();
        check("f_pc1002", pc, 64'h1002);
        drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        check("f_instr", {32'h0, instr_out}, {32'h0, NOP});
        check("f_ifid", {63'h0, if_id_write}, 64'h1);
        check("f_flush", {63'h0, if_flush}, 64'h0);
        check("f_prefault", {63'h0, fetch_fault}, 64'h0);
        tick();
        check("f_fault", {63'h0, fetch_fault}, 64'h1);
        check("f_fault_pc", fault_pc, 64'h1002);
        check("f_pc_hold", pc, 64'h1002);
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        check("fs_instr", {32'h0, instr_out}, {32'h0, NOP});
        check("fs_ifid", {63'h0, if_id_write}, 64'h1);
        tick();
        check("fs_pc_hold", pc, 64'h1002);
        check("fs_fault", {63'h0, fetch_fault}, 64'h1);
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        check("ta_flush", {63'h0, if_flush}, 64'h0);
        tick();
        check("ta_pc", pc, 64'h100);
        check("ta_fault", {63'h0, fetch_fault}, 64'h0);
        check("ta_fault_pc", fault_pc, 64'h1002);
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        tick();
        check("ta_run_pc", pc, 64'h104);

        // Fault at 0x104, then branch and trap_ack together: branch wins
        drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        check("f2_fault_pc", fault_pc, 64'h104);
        drive(1'b1, 1'b1, 64'h40, 1'b0, 1'b1);
        check("f2_flush", {63'h0, if_flush}, 64'h1);
        tick();
        check("f2_pc", pc, 64'h40);
        check("f2_fault", {63'h0, fetch_fault}, 64'h0);
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        tick();
        check("f2_run_pc", pc, 64'h44);

        // Wrap at top of address space
        drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
        tick();
        check("wrap_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        tick();
        check("wrap_zero", pc, 64'h0);

        // Reset asserted mid-FAULT discards the fault
        drive(1'b1, 1'b1, 64'h200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        check("mf_fault", {63'h0, fetch_fault}, 64'h1);
        rst_n = 1'b0;
        #1;
        check("mf_rst_pc", pc, 64'h0);
        check("mf_rst_fault", {63'h0, fetch_fault}, 64'h0);
        check("mf_rst_fault_pc", fault_pc, 64'h0);
        tick();
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        check("mf_boot_ifid", {63'h0, if_id_write}, 64'h0);

`ifdef PC_FETCH_PERF_CNT_EN
        // Counters: 3 normal fetches plus 1 branch
        check("cnt_rst_fetch", {32'h0, fetch_cnt}, 64'h0);
        check("cnt_rst_flush", {48'h0, flush_cnt}, 64'h0);
        tick();
        tick();
        tick();
        tick();
        drive(1'b1, 1'b1, 64'h300, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        check("cnt_fetch", {32'h0, fetch_cnt}, 64'h3);
        check("cnt_flush", {48'h0, flush_cnt}, 64'h1);
        rst_n = 1'b0;
        #1;
        check("cnt_clr_fetch", {32'h0, fetch_cnt}, 64'h0);
        check("cnt_clr_flush", {48'h0, flush_cnt}, 64'h0);
        rst_n = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VEC, 64'h0, PC value loaded at reset.
REQ-002 Parameter TRAP_VEC, 64'h100, PC value loaded on trap acknowledge.
REQ-003 Parameter NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 pc_write  in  1  hazard-unit enable; 0 = stall fetch.
REQ-007 branch_taken  in  1  redirect request from execute.
REQ-008 branch_target  in  64  redirect address.
REQ-009 inv_addr  in  1  invalid-address flag from the fetch memory for the current pc.
REQ-010 instr_in  in  32  instruction from the fetch memory for the current pc.
REQ-011 trap_ack  in  1  trap handler accepts a pending fetch fault.
REQ-012 pc  out  64  registered fetch address, drives the fetch memory and the IF/ID pc input.
REQ-013 instr_out  out  32  combinational instruction to the IF/ID register.
REQ-014 if_id_write  out  1  combinational IF/ID write enable.
REQ-015 if_flush  out  1  combinational; high while a redirect bubble is inserted.
REQ-016 fetch_fault  out  1  registered; high while in FAULT.
REQ-017 fault_pc  out  64  registered address that faulted.

Function
REQ-018 FSM states SHALL be BOOT, RUN, FAULT; BOOT lasts exactly one cycle after reset release, then moves to RUN with pc unchanged.
REQ-019 In BOOT: if_id_write=0, if_flush=0, instr_out=NOP_INSTR.
REQ-020 RUN priority SHALL be branch_taken > inv_addr > pc_write.
REQ-021 RUN, branch_taken=1 (pc_write ignored): next pc=branch_target, if_flush=1, if_id_write=1, instr_out=NOP_INSTR.
REQ-022 RUN, inv_addr=1, no branch: next state FAULT, fault_pc<=pc, fetch_fault<=1, pc held, if_id_write=1, instr_out=NOP_INSTR.
REQ-023 RUN, pc_write=0, no branch or fault: pc held, if_id_write=0, instr_out=instr_in.
REQ-024 RUN, normal: next pc=pc+4 (modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0), if_id_write=1, instr_out=instr_in.
REQ-025 FAULT: pc held, if_id_write=1, instr_out=NOP_INSTR every cycle; inv_addr and pc_write ignored.
REQ-026 FAULT, branch_taken=1: next pc=branch_target, fetch_fault<=0, state RUN, if_flush=1 (an older branch squashes the speculative fault); branch wins over a simultaneous trap_ack.
REQ-027 FAULT, trap_ack=1, no branch: next pc=TRAP_VEC, fetch_fault<=0, state RUN; fault_pc retains its value until the next fault.
REQ-028 trap_ack outside FAULT SHALL have no effect.
REQ-029 Latency: a redirect is visible on pc at the edge after branch_taken; fetch_fault rises at the edge after inv_addr.

Reset
REQ-030 On rst_n=0, asynchronously: pc=RESET_VEC, state BOOT, fetch_fault=0, fault_pc=0, and counters=0 when present.
REQ-031 Reset asserted mid-FAULT or mid-redirect SHALL discard the pending event; no output change occurs until the first edge after release.

Configuration
REQ-032 Macro PC_FETCH_PERF_CNT_EN, when defined, SHALL add the outputs fetch_cnt[31:0] and flush_cnt[15:0]. fetch_cnt increments once per cycle in which REQ-024 applies. flush_cnt increments once per cycle with if_flush=1. Both wrap on overflow.
REQ-033 Without PC_FETCH_PERF_CNT_EN, the counters and their ports SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Reset release, pc_write=1, inv_addr=0 for 4 cycles -> one BOOT cycle with if_id_write=0, then pc 0,4,8,C on successive cycles.
REQ-035 pc=0x10, pc_write=0 for 2 cycles -> pc stays 0x10, if_id_write=0; pc_write=1 -> pc goes to 0x14.
REQ-036 pc=0x20, branch_taken=1, target=0x80, pc_write=0 -> if_flush=1, instr_out=0x00000013, next pc=0x80.
REQ-037 inv_addr=1 at pc=0x1002 -> fetch_fault=1, fault_pc=0x1002, NOP bubbles; trap_ack=1 -> pc=0x100, fetch_fault=0.
REQ-038 In FAULT, branch_taken=1 and trap_ack=1 together, target=0x40 -> pc=0x40, state RUN, fetch_fault=0.
REQ-039 With PC_FETCH_PERF_CNT_EN defined: 3 normal fetches plus 1 branch -> fetch_cnt=3, flush_cnt=1; rst_n pulse low -> both counters 0.
